// File: rtl/i2s_tx_frac.sv
// Standard-I2S transmitter for 16-bit stereo audio. BCK timing comes from a
// fractional phase accumulator, so the long-term frame rate is exact.
module i2s_tx_frac #(
    parameter int unsigned CLK_HZ    = 32000000,
    parameter int unsigned SAMPLE_HZ = 48000
) (
    input  logic        clk32,
    input  logic        por,
    input  logic [15:0] audio_l,
    input  logic [15:0] audio_r,
    output logic        sample_stb,
    output logic        i2s_bck,
    output logic        i2s_ws,
    output logic        i2s_din
);

    if (64 * SAMPLE_HZ >= CLK_HZ) begin : g_bad_rate
        $error("i2s_tx_frac: 64*SAMPLE_HZ must be below CLK_HZ");
    end

    localparam logic [32:0] INC  = 33'(64 * SAMPLE_HZ);
    localparam logic [32:0] CLKW = 33'(CLK_HZ);

    logic [31:0] acc;
    logic [32:0] nxt;
    logic        tick;
    logic        bck;
    logic [4:0]  slot;
    logic [4:0]  slot_nx;
    logic [31:0] sr;

    always_comb begin
        nxt     = {1'b0, acc} + INC;
        tick    = (nxt >= CLKW);
        slot_nx = slot + 5'd1;
    end

    assign i2s_bck = bck;

    always_ff @(posedge clk32) begin
        if (por) begin
            acc        <= '0;
            bck        <= 1'b0;
            slot       <= '0;
            sr         <= '0;
            i2s_ws     <= 1'b0;
            i2s_din    <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            acc        <= tick ? 32'(nxt - CLKW) : nxt[31:0];
            if (tick) begin
                bck <= ~bck;
                // All data/word-select changes happen on the BCK falling edge.
                if (bck) begin
                    slot   <= slot_nx;
                    i2s_ws <= slot_nx[4];
                    if (slot_nx == 5'd1) begin
                        // MSB goes straight out, so the register is loaded pre-shifted.
                        sr         <= {audio_l[14:0], audio_r, 1'b0};
                        i2s_din    <= audio_l[15];
                        sample_stb <= 1'b1;
                    end else begin
                        i2s_din <= sr[31];
                        sr      <= {sr[30:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
